// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Four-digit, time-multiplexed seven-segment driver. An incoming packed BCD
//   word is held in a shadow register and only copied to the displayed word
//   at a scan-frame boundary, so one frame never mixes old and new digits.
//   Also provides leading-zero blanking, per-digit blinking, a dash glyph
//   (code 4'hB) and a frame-tick pulse for upstream pacing.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active low
//   load       one-cycle strobe, captures bcd_in
//   bcd_in     digit i = bcd_in[4i+3:4i], digit 0 rightmost
//   blank_lz   leading-zero blanking enable
//   blink_en   per-digit blink enable
//   DIGIT      active-low one-hot anode select
//   DISPLAY    active-low segments {a,b,c,d,e,f,g}
//   pending    shadow holds a word not yet committed
//   frame_tick one-cycle pulse when digit 0 starts a new frame
module seg7_scan_driver #(
    parameter int SCAN_W  = 15,
    parameter int BLINK_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic        blank_lz,
    input  logic [3:0]  blink_en,
    output logic [3:0]  DIGIT,
    output logic [6:0]  DISPLAY,
    output logic        pending,
    output logic        frame_tick
);

    logic [SCAN_W-1:0]  cnt;
    logic [1:0]         idx;
    logic [15:0]        shadow;
    logic [15:0]        shown;
    logic [BLINK_W-1:0] bcnt;
    logic               commit_q;

    logic       step;
    logic       commit;
    logic [3:0] code;
    logic       lz3, lz2, lz1;
    logic       blanked;
    logic       blink_off;
    logic [6:0] glyph;
    logic [6:0] seg_nxt;
    logic [3:0] digit_nxt;

    assign step   = &cnt;
    assign commit = step && (idx == 2'd3);

    always_comb begin
        code = shown[3:0];
        case (idx)
            2'd0: code = shown[3:0];
            2'd1: code = shown[7:4];
            2'd2: code = shown[11:8];
            2'd3: code = shown[15:12];
            default: code = shown[3:0];
        endcase
    end

    // Blanking ripples down from the leftmost digit; digit 0 always shows.
    assign lz3 = blank_lz && (shown[15:12] == 4'd0);
    assign lz2 = lz3 && (shown[11:8] == 4'd0);
    assign lz1 = lz2 && (shown[7:4] == 4'd0);

    always_comb begin
        blanked = 1'b0;
        case (idx)
            2'd3: blanked = lz3;
            2'd2: blanked = lz2;
            2'd1: blanked = lz1;
            default: blanked = 1'b0;
        endcase
    end

    assign blink_off = bcnt[BLINK_W-1] && blink_en[idx];

    always_comb begin
        glyph = 7'b1111111;
        case (code)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hB: glyph = 7'b1111110;
            default: glyph = 7'b1111111;
        endcase
    end

    assign seg_nxt   = (blanked || blink_off) ? 7'b1111111 : glyph;
    assign digit_nxt = ~(4'b0001 << idx);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            bcnt       <= '0;
            shadow     <= 16'hBBBB;
            shown      <= 16'hBBBB;
            pending    <= 1'b0;
            commit_q   <= 1'b0;
            frame_tick <= 1'b0;
            DIGIT      <= 4'b1111;
            DISPLAY    <= 7'b1111111;
        end else begin
            cnt  <= cnt + SCAN_W'(1);
            bcnt <= bcnt + BLINK_W'(1);
            if (step)
                idx <= idx + 2'd1;

            if (commit) begin
                // A word arriving on the boundary beats the older shadow.
                if (load) begin
                    shown  <= bcd_in;
                    shadow <= bcd_in;
                end else if (pending) begin
                    shown <= shadow;
                end
                pending <= 1'b0;
            end else if (load) begin
                shadow  <= bcd_in;
                pending <= 1'b1;
            end

            // commit updates idx/shown; the outputs reflect them one edge
            // later, so the tick is delayed twice to line up with DIGIT=1110.
            commit_q   <= commit;
            frame_tick <= commit_q;
            DIGIT      <= digit_nxt;
            DISPLAY    <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_en = 4'b0;
    logic [3:0]  DIGIT;
    logic [6:0]  DISPLAY;
    logic        pending;
    logic        frame_tick;

    seg7_scan_driver #(.SCAN_W(2), .BLINK_W(4)) dut (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
        .blank_lz(blank_lz), .blink_en(blink_en),
        .DIGIT(DIGIT), .DISPLAY(DISPLAY), .pending(pending),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph_of(input logic [3:0] c);
        case (c)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hB: return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       pend;
        logic       ft;
    } exp_t;

    exp_t q[$];

    // Model: everything is derived from the cycle count since reset release.
    // With SCAN_W=2, BLINK_W=4: idx = cyc[3:2], blink phase = cyc[3],
    // frame boundary when cyc%16 == 15.
    int          m_cyc = 0;
    logic [15:0] m_shadow = 16'hBBBB;
    logic [15:0] m_shown = 16'hBBBB;
    logic        m_pend = 1'b0;
    logic        m_cm_prev = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        int   i;
        logic lead, blk, cm;
        logic [3:0] code;
        if (!rst) begin
            e = '{dig: 4'b1111, seg: 7'b1111111, pend: 1'b0, ft: 1'b0};
            m_cyc = 0; m_shadow = 16'hBBBB; m_shown = 16'hBBBB;
            m_pend = 1'b0; m_cm_prev = 1'b0;
        end else begin
            i    = (m_cyc >> 2) & 3;
            code = m_shown[i*4 +: 4];
            lead = blank_lz;
            for (int k = 3; k > i; k--)
                if (m_shown[k*4 +: 4] != 4'd0) lead = 1'b0;
            blk = (i != 0) && lead && (code == 4'd0);
            if (blink_en[i] && ((m_cyc >> 3) & 1) == 1) blk = 1'b1;
            e.dig = ~(4'b0001 << i);
            e.seg = blk ? 7'b1111111 : glyph_of(code);
            e.ft  = m_cm_prev;
            cm = ((m_cyc % 16) == 15);
            m_cm_prev = cm;
            if (cm) begin
                if (load) m_shown = bcd_in;
                else if (m_pend) m_shown = m_shadow;
                m_pend = 1'b0;
            end else if (load) begin
                m_shadow = bcd_in;
                m_pend = 1'b1;
            end
            e.pend = m_pend;
            m_cyc++;
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("DIGIT", {12'h0, DIGIT}, {12'h0, e.dig});
            chk("DISPLAY", {9'h0, DISPLAY}, {9'h0, e.seg});
            chk("pending", {15'h0, pending}, {15'h0, e.pend});
            chk("frame_tick", {15'h0, frame_tick}, {15'h0, e.ft});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait until the upcoming edge is scan phase p (cyc%16), bounded.
    task automatic wait_phase(input int p);
        bit hit = 0;
        for (int k = 0; k < 64 && !hit; k++) begin
            if ((m_cyc % 16) == p) hit = 1;
            else @(negedge clk);
        end
        if (!hit) chk("wait_phase_timeout", 16'd0, 16'd1);
    endtask

    task automatic wait_ft();
        bit hit = 0;
        for (int k = 0; k < 64 && !hit; k++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) hit = 1;
        end
        if (!hit) chk("frame_tick_timeout", 16'd0, 16'd1);
    endtask

    task automatic do_load(input logic [15:0] w);
        load = 1'b1; bcd_in = w;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        cycles(3);
        chk("rst_DIGIT", {12'h0, DIGIT}, 16'h000F);
        chk("rst_DISPLAY", {9'h0, DISPLAY}, 16'h007F);
        chk("rst_pending", {15'h0, pending}, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        chk("first_DIGIT", {12'h0, DIGIT}, 16'h000E);
        chk("first_DISPLAY", {9'h0, DISPLAY}, 16'h007E);
        cycles(40);

        // load mid-frame at idx=1
        wait_phase(5);
        do_load(16'h1234);
        chk("pend_after_load", {15'h0, pending}, 16'h0001);
        wait_ft();
        chk("new_frame_DIGIT", {12'h0, DIGIT}, 16'h000E);
        chk("new_frame_seg4", {9'h0, DISPLAY}, 16'h004C);
        chk("pend_after_commit", {15'h0, pending}, 16'h0000);
        cycles(20);

        // two loads in one frame: last wins
        wait_phase(2);
        do_load(16'h1111);
        wait_phase(8);
        do_load(16'h2222);
        cycles(40);

        // load on the commit cycle itself
        wait_phase(15);
        do_load(16'h5555);
        chk("pend_commit_load", {15'h0, pending}, 16'h0000);
        cycles(32);

        // leading-zero blanking
        blank_lz = 1'b1;
        wait_phase(0); do_load(16'h0050); cycles(40);
        wait_phase(0); do_load(16'h0000); cycles(40);
        wait_phase(0); do_load(16'h0103); cycles(40);

        // dash / blank codes
        wait_phase(0); do_load(16'hBAFC); cycles(40);

        // blink digit 0
        blink_en = 4'b0001;
        wait_phase(0); do_load(16'h8888); cycles(64);
        blink_en = 4'b0000;

        // reset mid-operation with a pending word
        wait_phase(4); do_load(16'h4321);
        wait_phase(8);
        rst = 1'b0; load = 1'b1; bcd_in = 16'h9999;
        @(negedge clk);
        rst = 1'b1; load = 1'b0;
        chk("midrst_pending", {15'h0, pending}, 16'h0000);
        chk("midrst_DIGIT", {12'h0, DIGIT}, 16'h000F);
        @(negedge clk);
        chk("postrst_dash", {9'h0, DISPLAY}, 16'h007E);
        cycles(48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Four-digit, time-multiplexed seven-segment driver that sits directly downstream of the stopwatch/lap-record datapath and consumes its packed 16-bit BCD word. Captures each new word into a shadow register and commits it only at a scan-frame boundary, so no frame ever shows a mix of old and new digits. Adds leading-zero blanking, per-digit blinking, a dash glyph for error display, and a frame-tick output for upstream pacing.

## Interface
- SCAN_W, 15: scan counter width; each digit is lit for 2^SCAN_W clk cycles.
- BLINK_W, 24: blink counter width; blink phase = counter MSB, so the period is 2^BLINK_W cycles.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-low (sampled on posedge clk; rst=0 resets).
- load  in  1  single-cycle strobe; captures bcd_in into the shadow register.
- bcd_in  in  16  digit i = bcd_in[4i+3:4i]; digit 0 is rightmost.
- blank_lz  in  1  leading-zero blanking enable.
- blink_en  in  4  per-digit blink enable; bit i controls digit i.
- DIGIT  out  4  active-low one-hot anode select; digit i is lit when bit i = 0.
- DISPLAY  out  7  active-low segments {a,b,c,d,e,f,g}.
- pending  out  1  shadow register holds an uncommitted word.
- frame_tick  out  1  one-cycle pulse when digit 0 begins a new frame.

## Operation
- State:
  - cnt[SCAN_W-1:0]
  - idx[1:0]
  - shadow[15:0]
  - shown[15:0]
  - pending
  - bcnt[BLINK_W-1:0]
  - registered DIGIT, DISPLAY and frame_tick.
- step = (cnt == all-ones). cnt increments every cycle and wraps.
- On step, idx advances by 1 modulo 4 in the order 0,1,2,3,0.
- commit = step && idx==3, i.e. the frame boundary.
- load without commit: shadow <= bcd_in, pending <= 1. A later load before the boundary overwrites the shadow; the last load wins.
- commit with pending=1 and no load: shown <= shadow, pending <= 0.
- commit with load in the same cycle: shown <= bcd_in directly, pending <= 0. The incoming word wins over the older shadow.
- commit with pending=0 and no load: shown is unchanged.
- Glyphs:
  - 0→0000001
  - 1→1001111
  - 2→0010010
  - 3→0000110
  - 4→1001100
  - 5→0100100
  - 6→0100000
  - 7→0001111
  - 8→0000000
  - 9→0000100
  - 4'hB→1111110 (dash)
  - 4'hA and 4'hC–4'hF→1111111 (blank)
- Leading-zero blanking (blank_lz=1):
  - digit 3 is blanked if its code is 0.
  - digit k (k=2,1) is blanked if its code is 0 and digit k+1 is blanked.
  - digit 0 is never blanked by this rule.
- Blink: when bcnt[BLINK_W-1]=1 and blink_en[i]=1, digit i shows all segments off. DIGIT is still driven normally.
- Blanked digits keep their DIGIT select active and drive DISPLAY=1111111.

## Timing
- Reset values (rst=0 at a clk edge):
  - DIGIT=1111, DISPLAY=1111111, frame_tick=0, pending=0
  - cnt=0, idx=0, bcnt=0
  - shadow=shown=16'hBBBB, so four dashes show after reset.
- DIGIT and DISPLAY are registered from the current idx, shown, blank_lz, blink_en and bcnt. Latency is one cycle from a change of idx or shown to the outputs.
- First cycle after rst rises: the outputs show digit 0 (DIGIT=1110).
- frame_tick is registered high on the cycle after commit, i.e. the same cycle DIGIT first shows 1110 for the new frame.
- pending rises the cycle after load. It falls the cycle after commit.
- The maximum delay from load to display is 4·2^SCAN_W + 1 cycles.
- blank_lz and blink_en are combinational into the output register; there is no frame alignment, and a change takes effect within one cycle.
- Reset mid-frame aborts the scan, discards shadow and pending, and restores dashes. A load in the same cycle as rst=0 is ignored.

## Test plan
Run with SCAN_W=2 and BLINK_W=4.
- Reset: hold rst=0 for 3 cycles → DIGIT=1111, DISPLAY=1111111, pending=0. Release → DIGIT steps 1110,1101,1011,0111 every 4 cycles, DISPLAY=1111110 throughout, and frame_tick pulses every 16 cycles.
- Load mid-frame: load bcd_in=16'h1234 while idx=1 → pending=1 until the boundary. Next frame shows:
  - DIGIT 1110 with DISPLAY 1001100 ('4')
  - DIGIT 0111 with DISPLAY 1001111 ('1')
  - pending=0 the cycle after commit.
- Collisions:
  - Loads 16'h1111 then 16'h2222 in the same frame → only 2222 is displayed.
  - Load 16'h5555 exactly on the commit cycle → 5555 shows this frame and pending stays 0.
- Leading zeros with blank_lz=1:
  - 16'h0050 → digits 3 and 2 show 1111111, digit 1 shows 0100100, digit 0 shows 0000001.
  - 16'h0000 → only digit 0 shows '0'.
  - 16'h0103 → only digit 3 is blanked.
- Codes and blink:
  - 16'hBAFC → digit 3 shows a dash; digits 2, 1 and 0 are blank.
  - blink_en=0001 with 16'h8888 → digit 0 alternates 8 cycles all segments off / 8 cycles '8'; other digits are steady.
- Reset mid-operation: assert rst=0 with pending=1 at idx=2 → next cycle pending=0 and DIGIT=1111. After release, four dashes show and the pending word never appears.
